dclk_rx: RTL

- Serial receiver at the far end of a dclk_tx link; one instance per router input port.
- Frame on the wire, one bit per clk: start bit (1), then WIDTH data bits LSB-first, then line low. No stop bit appears on the wire, and there is at least one low cycle between frames.
- Deserialises each frame into a parallel flit, presents it to the input buffer with a valid/ack handshake, and drives channel_busy back to the transmitter as flow control.
- Sender and receiver clocks are the same frequency; their phase relationship is arbitrary.

---
 rtl/dclk_rx_pkg.sv | 7 +
 rtl/dclk_rx_if.sv | 8 +
 rtl/dclk_sync.sv | 12 +
 rtl/dclk_rx.sv | 74 +++++++
 4 files changed

// File: rtl/dclk_rx_pkg.sv
// dclk_rx_pkg: dclk link constants shared by dclk_rx and dclk_tx.
package dclk_rx_pkg;
  localparam int PAYLOAD_SIZE = 8;
  localparam int ADDR_SZ = 4;
  localparam int FLIT_W = PAYLOAD_SIZE + ADDR_SZ;
  typedef enum logic [1:0] {IDLE = 2'd0, RECV = 2'd1, HOLD = 2'd2} dclk_state_e;
endpackage

// File: rtl/dclk_rx_if.sv
// dclk_rx_if: received-flit handshake between dclk_rx and the input buffer.
interface dclk_rx_if #(parameter int WIDTH = 8);
  logic [WIDTH-1:0] parallel_out;
  logic rx_valid;
  logic rx_ack;
  modport master(output parallel_out, rx_valid, input rx_ack);
  modport slave(input parallel_out, rx_valid, output rx_ack);
endinterface

// File: rtl/dclk_sync.sv
// dclk_sync: 2-flop synchroniser with async active-low reset.
module dclk_sync (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);
  logic meta;
  always_ff @(posedge clk or negedge reset)
    if (!reset) {q, meta} <= 2'b00;
    else {q, meta} <= {meta, d};
endmodule

// File: rtl/dclk_rx.sv
// dclk_rx: serial frame receiver (start bit + WIDTH bits LSB-first) with
// valid/ack flit handoff and channel_busy flow control back to dclk_tx.
module dclk_rx
  import dclk_rx_pkg::*;
#(
  parameter int routerid = -1,
  parameter port = "unknown",
  parameter int WIDTH = FLIT_W,
  parameter bit SYNC_IN = 1'b1
) (
  input  logic clk,
  input  logic reset,
  input  logic serial_in,
  output logic channel_busy,
  output logic rx_active,
  dclk_rx_if.master rx
);
  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);
  if (WIDTH < 4) begin : g_width_chk
    $error("dclk_rx %0d/%s: WIDTH must be at least 4", routerid, port);
  end
  logic s;
  logic last;
  logic [WIDTH-1:0] shreg;
  logic [WIDTH-1:0] shin;
  logic [CW-1:0] bitcnt;
  dclk_state_e state, state_n;
  if (SYNC_IN) begin : g_sync
    dclk_sync u_sync (.clk(clk), .reset(reset), .d(serial_in), .q(s));
  end else begin : g_direct
    assign s = serial_in;
  end
  assign shin = {s, shreg[WIDTH-1:1]};
  assign last = bitcnt == LAST;
  always_ff @(posedge clk or negedge reset)
    if (!reset) state <= IDLE;
    else state <= state_n;
  always_comb begin
    state_n = state;
    state_n = (state == IDLE && s) ? RECV :
              (state == RECV && last) ? HOLD :
              (state == HOLD && rx.rx_ack) ? IDLE : state;
  end
  // Start bit is consumed on the IDLE->RECV edge; every RECV cycle is data.
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      shreg <= '0;
      bitcnt <= '0;
      rx.parallel_out <= '0;
      rx.rx_valid <= 1'b0;
      channel_busy <= 1'b0;
      rx_active <= 1'b0;
    end else begin
      if (state == IDLE && s) begin
        bitcnt <= '0;
        rx_active <= 1'b1;
        channel_busy <= 1'b1;
      end
      if (state == RECV) begin
        shreg <= shin;
        bitcnt <= bitcnt + 1'b1;
      end
      if (state == RECV && last) begin
        rx.parallel_out <= shin;
        rx.rx_valid <= 1'b1;
        rx_active <= 1'b0;
      end
      if (state == HOLD && rx.rx_ack) begin
        rx.rx_valid <= 1'b0;
        channel_busy <= 1'b0;
      end
    end
endmodule
